seg7_match_display: RTL

Downstream display stage for the serial pattern detector. Consumes the detector's match output `y` and its 8-bit state literal, counts matches in 3-digit BCD (000–999), and time-multiplexes a 4-digit common-anode seven-segment display. Digit 3 shows the detector's current state letter; digits 2..0 show the match count.

---
 rtl/seg7_match_display.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_match_display.sv
// seg7_match_display
//
// Display stage behind the serial pattern detector. Counts rising edges of
// the detector match output in three BCD digits (000-999, silent wrap) and
// scans a 4-digit common-anode seven-segment display:
//   digit 3      : detector state letter, passed through from st_literal
//   digits 2..0  : match count {hundreds, tens, units}
//
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to blank the leading zeros
// of the count. Blanked digits stay enabled on an and drive all segments off.
// Units is never blanked. bcd_cnt is the same in both builds.
//
// All outputs are active low, except bcd_cnt. seg bit order is {dp, g..a}.

module seg7_match_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        y,
    input  logic [7:0]  st_literal,
    input  logic        clr,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [11:0] bcd_cnt
);

    localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    localparam logic [7:0] SEG_DARK = 8'hFF;

    // seven-segment encoding of one BCD digit, dp off
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_DARK;
        endcase
        return s;
    endfunction

    logic             y_q;
    logic             rise;
    logic [3:0]       units;
    logic [3:0]       tens;
    logic [3:0]       hund;
    logic [3:0]       units_nxt;
    logic [3:0]       tens_nxt;
    logic [3:0]       hund_nxt;
    logic [PRE_W-1:0] pre;
    logic             pre_tc;
    logic [1:0]       idx;
    logic [3:0]       an_nxt;
    logic [7:0]       seg_nxt;
    logic             blank_hund;
    logic             blank_tens;

    // register y so a long high level on it counts only once.
    // y_q clears in reset, so y already high at release counts once.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y;
        end
    end

    assign rise = y & ~y_q;

    // BCD increment with ripple carry; 999 + 1 wraps to 000
    always_comb begin
        units_nxt = units;
        tens_nxt  = tens;
        hund_nxt  = hund;
        if (rise) begin
            if (units == 4'd9) begin
                units_nxt = 4'd0;
                if (tens == 4'd9) begin
                    tens_nxt = 4'd0;
                    if (hund == 4'd9) begin
                        hund_nxt = 4'd0;
                    end else begin
                        hund_nxt = hund + 4'd1;
                    end
                end else begin
                    tens_nxt = tens + 4'd1;
                end
            end else begin
                units_nxt = units + 4'd1;
            end
        end
    end

    // count register; clr overrides a coincident rise, which is dropped
    always_ff @(posedge Clock) begin
        if (Reset) begin
            units <= 4'd0;
            tens  <= 4'd0;
            hund  <= 4'd0;
        end else if (clr) begin
            units <= 4'd0;
            tens  <= 4'd0;
            hund  <= 4'd0;
        end else begin
            units <= units_nxt;
            tens  <= tens_nxt;
            hund  <= hund_nxt;
        end
    end

    assign bcd_cnt = {hund, tens, units};

    assign pre_tc = (pre == PRE_LAST);

    // refresh prescaler: 0..REFRESH_DIV-1, wrapping
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pre <= '0;
        end else if (pre_tc) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // digit index steps once per prescaler period; 2-bit wrap gives 3 -> 0
    always_ff @(posedge Clock) begin
        if (Reset) begin
            idx <= 2'd0;
        end else if (pre_tc) begin
            idx <= idx + 2'd1;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign blank_hund = (hund == 4'd0);
    assign blank_tens = (hund == 4'd0) && (tens == 4'd0);
`else
    assign blank_hund = 1'b0;
    assign blank_tens = 1'b0;
`endif

    // select digit enable and segment pattern for the current index
    always_comb begin
        an_nxt  = 4'b1111;
        seg_nxt = SEG_DARK;
        case (idx)
            2'd0: begin
                an_nxt  = 4'b1110;
                seg_nxt = enc(units);
            end
            2'd1: begin
                an_nxt  = 4'b1101;
                seg_nxt = blank_tens ? SEG_DARK : enc(tens);
            end
            2'd2: begin
                an_nxt  = 4'b1011;
                seg_nxt = blank_hund ? SEG_DARK : enc(hund);
            end
            default: begin
                an_nxt  = 4'b0111;
                seg_nxt = st_literal;
            end
        endcase
    end

    // an and seg load on the same edge so only one digit is ever enabled
    always_ff @(posedge Clock) begin
        if (Reset) begin
            an  <= 4'b1111;
            seg <= SEG_DARK;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule
